// File: rtl/dr_req_sched.sv
// Input scheduler for directory_bank: demand and prefetch FIFOs feeding one registered out stage.
// Demand has priority; a starvation counter forces a prefetch load after STARVE_MAX demand loads.
module dr_req_sched #(
    parameter int unsigned REQ_W      = 64,
    parameter int unsigned DQ_DEPTH   = 4,
    parameter int unsigned PQ_DEPTH   = 8,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_l2todr_req_valid,
    output logic             o_l2todr_req_retry,
    input  logic [REQ_W-1:0] i_l2todr_req,
    input  logic             i_l2todr_pfreq_valid,
    output logic             o_l2todr_pfreq_retry,
    input  logic [REQ_W-1:0] i_l2todr_pfreq,
    output logic             o_dr_req_valid,
    input  logic             i_dr_req_retry,
    output logic [REQ_W-1:0] o_dr_req,
    output logic             o_dr_req_is_pf,
    output logic             o_pf_drop,
    output logic [15:0]      o_pf_drop_cnt
);
    localparam int unsigned DQ_PW = $clog2(DQ_DEPTH);
    localparam int unsigned PQ_PW = $clog2(PQ_DEPTH);
    localparam logic [DQ_PW:0] DQ_FULL    = DQ_DEPTH[DQ_PW:0];
    localparam logic [PQ_PW:0] PQ_FULL    = PQ_DEPTH[PQ_PW:0];
    localparam logic [7:0]     STARVE_LIM = STARVE_MAX[7:0];

    logic [REQ_W-1:0] r_dq_mem [DQ_DEPTH];
    logic [DQ_PW-1:0] r_dq_rd, r_dq_wr;
    logic [DQ_PW:0]   r_dq_cnt;
    logic [REQ_W-1:0] r_pq_mem [PQ_DEPTH];
    logic [PQ_PW-1:0] r_pq_rd, r_pq_wr;
    logic [PQ_PW:0]   r_pq_cnt;
    logic [7:0]       r_starve;
    logic             r_out_valid, r_out_is_pf;
    logic [REQ_W-1:0] r_out_req;
    logic             r_pf_drop;
    logic [15:0]      r_pf_drop_cnt;

    logic w_dq_ne, w_pq_ne, w_dq_full, w_pq_full, w_dq_push, w_dq_pop, w_pq_pop;
    logic w_pq_drop, w_pq_inc, w_out_xfer, w_load, w_pick_pf;

    assign w_dq_ne    = (r_dq_cnt != '0);
    assign w_pq_ne    = (r_pq_cnt != '0);
    assign w_dq_full  = (r_dq_cnt == DQ_FULL);
    assign w_pq_full  = (r_pq_cnt == PQ_FULL);
    assign w_dq_push  = i_l2todr_req_valid && !w_dq_full;
    assign w_out_xfer = r_out_valid && !i_dr_req_retry;
    assign w_load     = (!r_out_valid || w_out_xfer) && (w_dq_ne || w_pq_ne);
    assign w_pick_pf  = w_pq_ne && (!w_dq_ne || (r_starve == STARVE_LIM));
    assign w_dq_pop   = w_load && !w_pick_pf;
    assign w_pq_pop   = w_load && w_pick_pf;
    // A same-cycle pop makes room, so only a push into a full, non-popping queue drops.
    assign w_pq_drop  = i_l2todr_pfreq_valid && w_pq_full && !w_pq_pop;
    assign w_pq_inc   = i_l2todr_pfreq_valid && !w_pq_drop;

    always_ff @(posedge i_clk) begin
        if (w_dq_push) r_dq_mem[r_dq_wr] <= i_l2todr_req;
        if (i_l2todr_pfreq_valid) r_pq_mem[r_pq_wr] <= i_l2todr_pfreq;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dq_rd  <= '0;
            r_dq_wr  <= '0;
            r_dq_cnt <= '0;
        end else begin
            if (w_dq_push) r_dq_wr <= r_dq_wr + 1'b1;
            if (w_dq_pop)  r_dq_rd <= r_dq_rd + 1'b1;
            r_dq_cnt <= r_dq_cnt + {{DQ_PW{1'b0}}, w_dq_push} - {{DQ_PW{1'b0}}, w_dq_pop};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pq_rd  <= '0;
            r_pq_wr  <= '0;
            r_pq_cnt <= '0;
        end else begin
            if (i_l2todr_pfreq_valid)  r_pq_wr <= r_pq_wr + 1'b1;
            if (w_pq_pop || w_pq_drop) r_pq_rd <= r_pq_rd + 1'b1;
            r_pq_cnt <= r_pq_cnt + {{PQ_PW{1'b0}}, w_pq_inc} - {{PQ_PW{1'b0}}, w_pq_pop};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_out_valid <= 1'b0;
            r_out_is_pf <= 1'b0;
            r_out_req   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_is_pf <= w_pick_pf;
            r_out_req   <= w_pick_pf ? r_pq_mem[r_pq_rd] : r_dq_mem[r_dq_rd];
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_starve <= '0;
        end else if (!w_pq_ne || w_pq_pop) begin
            r_starve <= '0;
        end else if (w_dq_pop && (r_starve != STARVE_LIM)) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pf_drop     <= 1'b0;
            r_pf_drop_cnt <= '0;
        end else begin
            r_pf_drop <= w_pq_drop;
            if (w_pq_drop && (r_pf_drop_cnt != 16'hFFFF)) r_pf_drop_cnt <= r_pf_drop_cnt + 16'd1;
        end
    end

    assign o_l2todr_req_retry   = w_dq_full;
    assign o_l2todr_pfreq_retry = 1'b0;
    assign o_dr_req_valid       = r_out_valid;
    assign o_dr_req             = r_out_req;
    assign o_dr_req_is_pf       = r_out_is_pf;
    assign o_pf_drop            = r_pf_drop;
    assign o_pf_drop_cnt        = r_pf_drop_cnt;
endmodule

// File: tb/tb_dr_req_sched.sv
// Bench for dr_req_sched: queue-based reference model compared every cycle, plus directed
// scenarios with hand-computed expectations and a randomized soak with a mid-run reset.
module tb_dr_req_sched;
    localparam int unsigned W  = 16;
    localparam int unsigned DQ = 4;
    localparam int unsigned PQ = 8;
    localparam int unsigned SM = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         d_v = 1'b0;
    logic [W-1:0] d_data = '0;
    logic         p_v = 1'b0;
    logic [W-1:0] p_data = '0;
    logic         dr_retry = 1'b0;
    logic         o_d_retry, o_p_retry, o_valid, o_is_pf, o_drop;
    logic [W-1:0] o_req;
    logic [15:0]  o_drop_cnt;

    always #5 clk = ~clk;

    dr_req_sched #(
        .REQ_W      (W),
        .DQ_DEPTH   (DQ),
        .PQ_DEPTH   (PQ),
        .STARVE_MAX (SM)
    ) u_dut (
        .i_clk                (clk),
        .i_reset              (rst_n),
        .i_l2todr_req_valid   (d_v),
        .o_l2todr_req_retry   (o_d_retry),
        .i_l2todr_req         (d_data),
        .i_l2todr_pfreq_valid (p_v),
        .o_l2todr_pfreq_retry (o_p_retry),
        .i_l2todr_pfreq       (p_data),
        .o_dr_req_valid       (o_valid),
        .i_dr_req_retry       (dr_retry),
        .o_dr_req             (o_req),
        .o_dr_req_is_pf       (o_is_pf),
        .o_pf_drop            (o_drop),
        .o_pf_drop_cnt        (o_drop_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: two queues, an out slot and a starvation counter.
    logic [W-1:0] m_dq[$];
    logic [W-1:0] m_pq[$];
    bit           m_out_v, m_out_pf, m_drop, m_acc;
    logic [W-1:0] m_out_req;
    int           m_starve, m_drop_cnt;
    logic [W:0]   dut_log[$];

    task automatic mreset();
        m_dq.delete();
        m_pq.delete();
        m_out_v = 0; m_out_pf = 0; m_out_req = '0;
        m_starve = 0; m_drop = 0; m_drop_cnt = 0; m_acc = 0;
    endtask

    task automatic mstep();
        bit dq_ne, pq_ne, xfer, load, pick_pf, pf_pop;
        logic [W-1:0] junk;
        dq_ne   = (m_dq.size() != 0);
        pq_ne   = (m_pq.size() != 0);
        xfer    = m_out_v && !dr_retry;
        load    = (!m_out_v || xfer) && (dq_ne || pq_ne);
        pick_pf = pq_ne && (!dq_ne || (m_starve == SM));
        pf_pop  = load && pick_pf;
        m_acc   = d_v && (m_dq.size() < DQ);
        m_drop  = p_v && (m_pq.size() == PQ) && !pf_pop;
        if (m_drop && (m_drop_cnt < 32'hFFFF)) m_drop_cnt++;
        if (xfer) m_out_v = 0;
        if (load) begin
            m_out_v  = 1;
            m_out_pf = pick_pf;
            if (pick_pf) m_out_req = m_pq.pop_front();
            else         m_out_req = m_dq.pop_front();
        end
        if (m_drop) junk = m_pq.pop_front();
        if (m_acc) m_dq.push_back(d_data);
        if (p_v)   m_pq.push_back(p_data);
        if (!pq_ne || pf_pop) m_starve = 0;
        else if (load && (m_starve < SM)) m_starve++;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else        mstep();
        end
    end

    // Per-cycle comparison against the model, and a log of what the DUT transferred.
    initial begin
        forever begin
            @(negedge clk);
            chk("dr_req_valid", {31'd0, o_valid}, {31'd0, m_out_v});
            if (m_out_v) begin
                chk("dr_req", {16'd0, o_req}, {16'd0, m_out_req});
                chk("dr_req_is_pf", {31'd0, o_is_pf}, {31'd0, m_out_pf});
            end
            chk("l2todr_req_retry", {31'd0, o_d_retry}, {31'd0, m_dq.size() == DQ});
            chk("l2todr_pfreq_retry", {31'd0, o_p_retry}, 32'd0);
            chk("pf_drop", {31'd0, o_drop}, {31'd0, m_drop});
            chk("pf_drop_cnt", {16'd0, o_drop_cnt}, m_drop_cnt);
            if (rst_n && o_valid && !dr_retry) dut_log.push_back({o_is_pf, o_req});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; d_v = 1'b0; p_v = 1'b0; dr_retry = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int acc, drops, k, dprob, pprob, rprob;
        logic [W:0] e;

        // Reset held with random inputs
        #1;
        for (int c = 0; c < 6; c++) begin
            d_v = 1'($urandom); p_v = 1'($urandom); dr_retry = 1'($urandom);
            d_data = W'($urandom); p_data = W'($urandom);
            @(negedge clk);
            chk("reset_valid", {31'd0, o_valid}, 32'd0);
            chk("reset_is_pf", {31'd0, o_is_pf}, 32'd0);
            chk("reset_drop_cnt", {16'd0, o_drop_cnt}, 32'd0);
            cyc();
        end
        d_v = 0; p_v = 0; dr_retry = 0;
        rst_n = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("idle_valid", {31'd0, o_valid}, 32'd0);
        chk("idle_retry", {31'd0, o_d_retry}, 32'd0);

        // Single demand: valid only two cycles after acceptance
        cyc();
        d_v = 1; d_data = 16'h0123;
        @(negedge clk);
        chk("lat_c0_valid", {31'd0, o_valid}, 32'd0);
        cyc(); d_v = 0;
        @(negedge clk);
        chk("lat_c1_valid", {31'd0, o_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("lat_c2_valid", {31'd0, o_valid}, 32'd1);
        chk("lat_c2_data", {16'd0, o_req}, 32'h0123);
        chk("lat_c2_is_pf", {31'd0, o_is_pf}, 32'd0);
        cyc();
        @(negedge clk);
        chk("lat_c3_valid", {31'd0, o_valid}, 32'd0);
        cyc(); cyc();

        // Demand back-pressure: 5 accepted while the bank refuses
        dut_log.delete();
        dr_retry = 1; d_v = 1; d_data = 16'h0100; acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 5) chk("retry_from_c5", {31'd0, o_d_retry}, 32'd1);
            if (!o_d_retry) acc++;
            cyc();
            d_data = W'(16'h0100 + acc);
        end
        d_v = 0;
        chk("demand_accepted", acc, 32'd5);
        dr_retry = 0;
        repeat (10) cyc();
        chk("demand_out_count", dut_log.size(), 32'd5);
        for (int i = 0; i < 5 && i < dut_log.size(); i++) begin
            e = {1'b0, W'(16'h0100 + i)};
            chk("demand_order", {15'd0, dut_log[i]}, {15'd0, e});
        end

        // Prefetch overflow: P10 drops P2
        dut_log.delete();
        dr_retry = 1; drops = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 10) begin p_v = 1; p_data = W'(16'h8001 + c); end
            else p_v = 0;
            @(negedge clk);
            if (o_drop) drops++;
            cyc();
        end
        chk("pf_drop_pulses", drops, 32'd1);
        chk("pf_drop_cnt_one", {16'd0, o_drop_cnt}, 32'd1);
        dr_retry = 0;
        repeat (14) cyc();
        chk("pf_out_count", dut_log.size(), 32'd9);
        for (int i = 0; i < 9 && i < dut_log.size(); i++) begin
            e = {1'b1, W'(16'h8001 + ((i == 0) ? 0 : i + 1))};
            chk("pf_order", {15'd0, dut_log[i]}, {15'd0, e});
        end

        // Both queues busy: 8 demand loads then 1 prefetch, repeating
        do_reset();
        dut_log.delete();
        d_v = 1; p_v = 1; d_data = 16'h4000; p_data = 16'h9000;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            acc = o_d_retry ? 0 : 1;
            cyc();
            if (acc == 1) d_data = d_data + 1'b1;
            p_data = W'(16'h9001 + c);
        end
        d_v = 0; p_v = 0;
        k = -1;
        for (int j = 0; j < dut_log.size(); j++) if (k < 0 && dut_log[j][W]) k = j;
        chk("arb_first_pf", k, 32'd8);
        chk("arb_log_size", {31'd0, dut_log.size() >= 45}, 32'd1);
        if (k >= 0)
            for (int j = k; j < k + 36 && j < dut_log.size(); j++)
                chk("arb_pattern", {31'd0, dut_log[j][W]}, {31'd0, ((j - k) % 9) == 0});
        repeat (20) cyc();

        // Full PQ with push and pop in the same cycle: no drop
        do_reset();
        dut_log.delete();
        dr_retry = 1;
        for (int c = 0; c < 9; c++) begin
            p_v = 1; p_data = W'(16'hA001 + c);
            cyc();
        end
        p_v = 0;
        cyc();
        dr_retry = 0; p_v = 1; p_data = 16'hA00A;
        cyc();
        p_v = 0;
        @(negedge clk);
        chk("full_pop_no_drop", {31'd0, o_drop}, 32'd0);
        chk("full_pop_cnt", {16'd0, o_drop_cnt}, 32'd0);
        repeat (14) cyc();
        chk("full_pop_count", dut_log.size(), 32'd10);
        for (int i = 0; i < 10 && i < dut_log.size(); i++) begin
            e = {1'b1, W'(16'hA001 + i)};
            chk("full_pop_order", {15'd0, dut_log[i]}, {15'd0, e});
        end

        // Randomized soak with a reset in the middle
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            case (c / 1000)
                0:       begin dprob = 70; pprob = 30; rprob = 20; end
                1:       begin dprob = 90; pprob = 90; rprob = 70; end
                2:       begin dprob = 30; pprob = 60; rprob = 5;  end
                default: begin dprob = 50; pprob = 50; rprob = 50; end
            endcase
            if (c == 2500) rst_n = 1'b0;
            if (c == 2503) rst_n = 1'b1;
            if (!(d_v && !m_acc)) begin
                d_v = ($urandom_range(0, 99) < dprob);
                d_data = W'($urandom);
            end
            p_v = ($urandom_range(0, 99) < pprob);
            p_data = W'($urandom);
            dr_retry = ($urandom_range(0, 99) < rprob);
            cyc();
        end
        d_v = 0; p_v = 0; dr_retry = 0;
        repeat (20) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
